// File: rtl/hash_feeder_if.sv
// Byte-stream, hash-lookup, candidate and block-status signals of the LZ4 hash feeder.
// The master modport is the feeder itself; slave is the surrounding environment.
interface hash_feeder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 15
);
  logic [7:0]        byte_in;
  logic              byte_ivalid;
  logic              byte_ilast;
  logic              byte_iready;

  logic              hash_clean;
  logic              hash_unable;
  logic [31:0]       hash_idata;
  logic [ADDR_W-1:0] hash_iaddr;
  logic              hash_ivalid;
  logic [ADDR_W-1:0] hash_oaddr;
  logic              hash_ovalid;
  logic              hash_hit;

  logic              cand_valid;
  logic              cand_ready;
  logic [31:0]       cand_data;
  logic [ADDR_W-1:0] cand_cur_addr;
  logic [ADDR_W-1:0] cand_match_addr;
  logic              cand_hit;

  logic              blk_done;
  logic [CNT_W-1:0]  blk_len;

  modport master (
    input  byte_in, byte_ivalid, byte_ilast,
    input  hash_unable, hash_oaddr, hash_ovalid, hash_hit,
    input  cand_ready,
    output byte_iready,
    output hash_clean, hash_idata, hash_iaddr, hash_ivalid,
    output cand_valid, cand_data, cand_cur_addr, cand_match_addr, cand_hit,
    output blk_done, blk_len
  );

  modport slave (
    output byte_in, byte_ivalid, byte_ilast,
    output hash_unable, hash_oaddr, hash_ovalid, hash_hit,
    output cand_ready,
    input  byte_iready,
    input  hash_clean, hash_idata, hash_iaddr, hash_ivalid,
    input  cand_valid, cand_data, cand_cur_addr, cand_match_addr, cand_hit,
    input  blk_done, blk_len
  );
endinterface

// File: rtl/hash_feeder.sv
// LZ4 hash feeder: 4-byte sliding window -> one hash lookup at a time -> candidate, blocks of BLOCK_SIZE bytes.
// Lookup strobe >=1 cycle after the completing byte; input stalls (byte_iready=0) from lookup issue until candidate accepted.
module hash_feeder #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_SIZE = 16384,
  parameter int CNT_W      = 15
) (
  input  logic          clk,
  input  logic          rstN,
  hash_feeder_if.master bus
);

  localparam logic [2:0] ST_FILL  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_OUT   = 3'd3;
  localparam logic [2:0] ST_CLEAN = 3'd4;
  localparam logic [2:0] ST_CWAIT = 3'd5;

  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_SIZE);

  logic [2:0]        state;
  logic [31:0]       win;
  logic [1:0]        fill;
  logic [CNT_W-1:0]  bcnt;
  logic              end_flag;
  logic [ADDR_W-1:0] req_addr;

  logic [31:0]       cand_data_q;
  logic [ADDR_W-1:0] cand_cur_q;
  logic [ADDR_W-1:0] cand_match_q;
  logic              cand_hit_q;
  logic [CNT_W-1:0]  blk_len_q;

  logic [CNT_W-1:0]  bcnt_inc;
  logic              win_full;
  logic              blk_end;

  // fill==3 means the window already holds three bytes of this block, so the next byte completes it
  assign bcnt_inc = bcnt + 1'b1;
  assign win_full = (fill == 2'd3);
  assign blk_end  = bus.byte_ilast || (bcnt_inc == BLK_LAST);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state        <= ST_FILL;
      win          <= '0;
      fill         <= '0;
      bcnt         <= '0;
      end_flag     <= 1'b0;
      req_addr     <= '0;
      cand_data_q  <= '0;
      cand_cur_q   <= '0;
      cand_match_q <= '0;
      cand_hit_q   <= 1'b0;
      blk_len_q    <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (bus.byte_ivalid) begin
            win  <= {win[23:0], bus.byte_in};
            bcnt <= bcnt_inc;
            if (win_full) begin
              req_addr <= ADDR_W'(bcnt_inc - CNT_W'(3));
              end_flag <= blk_end;
              state    <= ST_REQ;
            end else begin
              fill <= fill + 2'd1;
              if (blk_end) begin
                state <= ST_CLEAN;
              end
            end
          end
        end
        ST_REQ: begin
          if (!bus.hash_unable) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.hash_ovalid) begin
            cand_data_q  <= win;
            cand_cur_q   <= req_addr;
            cand_match_q <= bus.hash_oaddr;
            cand_hit_q   <= bus.hash_hit;
            state        <= ST_OUT;
          end
        end
        ST_OUT: begin
          // fill stays at 3: one more byte after the handshake slides the window by one
          if (bus.cand_ready) begin
            state <= end_flag ? ST_CLEAN : ST_FILL;
          end
        end
        ST_CLEAN: begin
          blk_len_q <= bcnt;
          state     <= ST_CWAIT;
        end
        ST_CWAIT: begin
          if (!bus.hash_unable) begin
            win      <= '0;
            fill     <= '0;
            bcnt     <= '0;
            end_flag <= 1'b0;
            state    <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign bus.byte_iready     = (state == ST_FILL);
  assign bus.hash_ivalid     = (state == ST_REQ) && !bus.hash_unable;
  assign bus.hash_idata      = win;
  assign bus.hash_iaddr      = req_addr;
  assign bus.hash_clean      = (state == ST_CLEAN);
  assign bus.blk_done        = (state == ST_CLEAN);
  // blk_len must already be valid during the blk_done cycle, before blk_len_q has captured it
  assign bus.blk_len         = (state == ST_CLEAN) ? bcnt : blk_len_q;
  assign bus.cand_valid      = (state == ST_OUT);
  assign bus.cand_data       = cand_data_q;
  assign bus.cand_cur_addr   = cand_cur_q;
  assign bus.cand_match_addr = cand_match_q;
  assign bus.cand_hit        = cand_hit_q;

endmodule

// File: tb/tb_hash_feeder.sv
// Directed bench for hash_feeder: vector table of short streams plus hand sequences for stalls, block split and reset.
module tb_hash_feeder;
  localparam int ADDR_W     = 32;
  localparam int BLOCK_SIZE = 16384;
  localparam int CNT_W      = 15;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  hash_feeder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  hash_feeder #(.ADDR_W(ADDR_W), .BLOCK_SIZE(BLOCK_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstN(rstN), .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] m;
    logic        h;
  } rec_t;

  typedef struct {
    string       txt;
    logic        hit;
    int          exp_lk;
    int          exp_len;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_last_addr;
  } vec_t;

  rec_t       lk_q[$];
  rec_t       cand_q[$];
  int         done_q[$];
  logic [7:0] strm[$];
  int         clean_err = 0;
  int         flight_err = 0;
  int         resp_cnt = 0;
  int         lat = 2;
  logic       hit_en = 1'b0;
  logic [31:0] resp_word = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic logic [31:0] match_of(input logic [31:0] w);
    return w ^ 32'h00ff00ff;
  endfunction

  function automatic logic hit_of(input logic [31:0] w, input logic en);
    return en & (^w);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Hash table model and monitor: responses driven at +1, DUT outputs sampled at +2.
  initial begin
    bus.hash_ovalid = 1'b0;
    bus.hash_oaddr  = '0;
    bus.hash_hit    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.hash_ovalid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.hash_ovalid = 1'b1;
          bus.hash_oaddr  = match_of(resp_word);
          bus.hash_hit    = hit_of(resp_word, hit_en);
        end
      end
      #1;
      if (bus.hash_ivalid === 1'b1) begin
        if (resp_cnt != 0) flight_err++;
        lk_q.push_back('{d: bus.hash_idata, a: bus.hash_iaddr, m: 32'h0, h: 1'b0});
        resp_cnt  = lat;
        resp_word = bus.hash_idata;
      end
      if (bus.cand_valid === 1'b1 && bus.cand_ready === 1'b1)
        cand_q.push_back('{d: bus.cand_data, a: bus.cand_cur_addr, m: bus.cand_match_addr, h: bus.cand_hit});
      if (bus.blk_done === 1'b1) done_q.push_back(int'(bus.blk_len));
      if (bus.hash_clean !== bus.blk_done) clean_err++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    lk_q.delete();
    cand_q.delete();
    done_q.delete();
    strm.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus.byte_in     = b;
    bus.byte_ilast  = last;
    bus.byte_ivalid = 1'b1;
    #1;
    while (bus.byte_iready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL send_byte: byte_iready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1;
    bus.byte_ivalid = 1'b0;
    bus.byte_ilast  = 1'b0;
  endtask

  task automatic send_stream();
    for (int i = 0; i < strm.size(); i++) send_byte(strm[i], i == strm.size() - 1);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k;
    k = 0;
    while (done_q.size() < n && k < 5000) begin
      tick();
      k++;
    end
    chk({tag, "_blk_done_count"}, 64'(done_q.size()), 64'(n));
  endtask

  // Expected lookups/candidates/blocks derived from the stream alone.
  task automatic check_model(input string tag);
    rec_t exp_q[$];
    int   lens[$];
    int   err_l, err_c, err_b, n;
    err_l = 0; err_c = 0; err_b = 0;
    n = strm.size();
    for (int s = 0; s < n; s += BLOCK_SIZE) begin
      int len;
      len = (n - s < BLOCK_SIZE) ? n - s : BLOCK_SIZE;
      lens.push_back(len);
      for (int k = 1; k <= len - 3; k++) begin
        logic [31:0] w;
        w = {strm[s+k-1], strm[s+k], strm[s+k+1], strm[s+k+2]};
        exp_q.push_back('{d: w, a: 32'(k), m: match_of(w), h: hit_of(w, hit_en)});
      end
    end
    chk({tag, "_lookup_count"}, 64'(lk_q.size()), 64'(exp_q.size()));
    chk({tag, "_cand_count"}, 64'(cand_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < lk_q.size(); i++)
      if (lk_q[i].d !== exp_q[i].d || lk_q[i].a !== exp_q[i].a) err_l++;
    for (int i = 0; i < exp_q.size() && i < cand_q.size(); i++)
      if (cand_q[i] != exp_q[i]) err_c++;
    for (int i = 0; i < lens.size() && i < done_q.size(); i++)
      if (done_q[i] != lens[i]) err_b++;
    chk({tag, "_lookup_seq_errors"}, 64'(err_l), 64'(0));
    chk({tag, "_cand_seq_errors"}, 64'(err_c), 64'(0));
    chk({tag, "_blk_len_errors"}, 64'(err_b), 64'(0));
  endtask

  task automatic reset_chk(input string t);
    chk({t, "_byte_iready"}, 64'(bus.byte_iready), 64'(1));
    chk({t, "_hash_ivalid"}, 64'(bus.hash_ivalid), 64'(0));
    chk({t, "_hash_idata"}, 64'(bus.hash_idata), 64'(0));
    chk({t, "_hash_iaddr"}, 64'(bus.hash_iaddr), 64'(0));
    chk({t, "_hash_clean"}, 64'(bus.hash_clean), 64'(0));
    chk({t, "_blk_done"}, 64'(bus.blk_done), 64'(0));
    chk({t, "_blk_len"}, 64'(bus.blk_len), 64'(0));
    chk({t, "_cand_valid"}, 64'(bus.cand_valid), 64'(0));
    chk({t, "_cand_fields"}, 64'({bus.cand_data, bus.cand_match_addr} | 64'(bus.cand_cur_addr) | 64'(bus.cand_hit)), 64'(0));
  endtask

  initial begin
    vec_t vecs[6];
    int   iv, derr, aerr, verr, ferr, rerr, k;

    vecs[0] = '{"abcdef",   1'b0, 3, 6, 32'h61626364, 32'h63646566, 3};
    vecs[1] = '{"ab",       1'b0, 0, 2, 32'h0,        32'h0,        0};
    vecs[2] = '{"abc",      1'b1, 0, 3, 32'h0,        32'h0,        0};
    vecs[3] = '{"abcd",     1'b1, 1, 4, 32'h61626364, 32'h61626364, 1};
    vecs[4] = '{"z",        1'b0, 0, 1, 32'h0,        32'h0,        0};
    vecs[5] = '{"ABCDEFGH", 1'b1, 5, 8, 32'h41424344, 32'h45464748, 5};

    rstN = 1'b0;
    bus.byte_in = 8'h0; bus.byte_ivalid = 1'b0; bus.byte_ilast = 1'b0;
    bus.hash_unable = 1'b0; bus.cand_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_chk("reset");
    @(posedge clk);
    #1;
    rstN = 1'b1;
    tick();

    // Short streams from the vector table
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      hit_en = vecs[v].hit;
      lat = 2;
      for (int i = 0; i < vecs[v].txt.len(); i++) strm.push_back(vecs[v].txt[i]);
      send_stream();
      wait_done($sformatf("v%0d", v), 1);
      chk($sformatf("v%0d_lookups", v), 64'(lk_q.size()), 64'(vecs[v].exp_lk));
      chk($sformatf("v%0d_blk_len", v), 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(vecs[v].exp_len));
      chk($sformatf("v%0d_first_data", v), 64'(lk_q.size() > 0 ? lk_q[0].d : 32'h0), 64'(vecs[v].exp_first));
      chk($sformatf("v%0d_last_data", v), 64'(lk_q.size() > 0 ? lk_q[lk_q.size()-1].d : 32'h0), 64'(vecs[v].exp_last));
      chk($sformatf("v%0d_last_addr", v), 64'(lk_q.size() > 0 ? lk_q[lk_q.size()-1].a : 32'h0), 64'(vecs[v].exp_last_addr));
      check_model($sformatf("v%0d", v));
    end

    // hash_unable held while a lookup is pending
    clear_logs();
    hit_en = 1'b1; lat = 2;
    strm = '{8'h77, 8'h78, 8'h79, 8'h7a, 8'h71};
    send_byte(8'h77, 1'b0); send_byte(8'h78, 1'b0); send_byte(8'h79, 1'b0);
    bus.hash_unable = 1'b1;
    send_byte(8'h7a, 1'b0);
    iv = 0; derr = 0; aerr = 0; rerr = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.hash_ivalid !== 1'b0) iv++;
      if (bus.hash_idata !== 32'h7778797a) derr++;
      if (bus.hash_iaddr !== 32'd1) aerr++;
      if (bus.byte_iready !== 1'b0) rerr++;
      @(posedge clk);
      #1;
    end
    chk("unable_ivalid_count", 64'(iv), 64'(0));
    chk("unable_data_changes", 64'(derr), 64'(0));
    chk("unable_addr_changes", 64'(aerr), 64'(0));
    chk("unable_iready_high", 64'(rerr), 64'(0));
    chk("unable_no_lookup_logged", 64'(lk_q.size()), 64'(0));
    bus.hash_unable = 1'b0;
    #1;
    chk("unable_release_pulse", 64'(bus.hash_ivalid), 64'(1));
    @(posedge clk);
    #2;
    chk("unable_single_pulse", 64'(bus.hash_ivalid), 64'(0));
    @(posedge clk);
    #1;
    send_byte(8'h71, 1'b1);
    wait_done("unable", 1);
    chk("unable_first_data", 64'(lk_q.size() > 0 ? lk_q[0].d : 32'h0), 64'h7778797a);
    chk("unable_blk_len", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(5));
    check_model("unable");

    // Downstream stall on a candidate
    clear_logs();
    hit_en = 1'b1; lat = 2;
    strm = '{8'h6d, 8'h6e, 8'h6f, 8'h70, 8'h71};
    bus.cand_ready = 1'b0;
    send_byte(8'h6d, 1'b0); send_byte(8'h6e, 1'b0); send_byte(8'h6f, 1'b0); send_byte(8'h70, 1'b0);
    k = 0;
    while (bus.cand_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("stall_cand_valid_up", 64'(bus.cand_valid), 64'(1));
    verr = 0; ferr = 0; rerr = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.cand_valid !== 1'b1) verr++;
      if (bus.cand_data !== 32'h6d6e6f70 || bus.cand_cur_addr !== 32'd1 ||
          bus.cand_match_addr !== 32'h6d916f8f || bus.cand_hit !== 1'b1) ferr++;
      if (bus.byte_iready !== 1'b0) rerr++;
      tick();
    end
    chk("stall_valid_drops", 64'(verr), 64'(0));
    chk("stall_field_changes", 64'(ferr), 64'(0));
    chk("stall_iready_high", 64'(rerr), 64'(0));
    chk("stall_lookup_count", 64'(lk_q.size()), 64'(1));
    chk("stall_cand_count", 64'(cand_q.size()), 64'(0));
    bus.cand_ready = 1'b1;
    #1;
    @(posedge clk);
    #1;
    chk("stall_cand_valid_drop", 64'(bus.cand_valid), 64'(0));
    send_byte(8'h71, 1'b1);
    wait_done("stall", 1);
    chk("stall_blk_len", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(5));
    check_model("stall");

    // Stream longer than one block
    clear_logs();
    hit_en = 1'b1; lat = 1;
    for (int i = 0; i < 16390; i++) strm.push_back(8'((i * 13 + 7) & 255));
    send_stream();
    wait_done("long", 2);
    chk("long_blk1_len", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(16384));
    chk("long_blk2_len", 64'(done_q.size() > 1 ? done_q[1] : -1), 64'(6));
    chk("long_blk1_last_addr", 64'(lk_q.size() > 16380 ? lk_q[16380].a : 32'hffffffff), 64'(16381));
    chk("long_blk2_first_addr", 64'(lk_q.size() > 16381 ? lk_q[16381].a : 32'hffffffff), 64'(1));
    check_model("long");

    // Reset while a lookup is outstanding
    clear_logs();
    hit_en = 1'b0; lat = 6;
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b0); send_byte(8'h64, 1'b0);
    tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    #1;
    reset_chk("midrst");
    @(posedge clk);
    #1;
    verr = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.cand_valid !== 1'b0) verr++;
      tick();
    end
    chk("midrst_late_ovalid_ignored", 64'(verr), 64'(0));
    chk("midrst_no_cand", 64'(cand_q.size()), 64'(0));
    chk("midrst_no_blk_done", 64'(done_q.size()), 64'(0));
    clear_logs();
    lat = 2;
    strm = '{8'h65, 8'h66, 8'h67, 8'h68};
    send_stream();
    wait_done("midrst", 1);
    chk("midrst_restart_addr", 64'(lk_q.size() > 0 ? lk_q[0].a : 32'h0), 64'(1));
    chk("midrst_restart_data", 64'(lk_q.size() > 0 ? lk_q[0].d : 32'h0), 64'h65666768);
    check_model("midrst");

    chk("clean_with_done", 64'(clean_err), 64'(0));
    chk("one_in_flight", 64'(flight_err), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
